// File: rtl/ps2_key_ctrl_if.sv
// Bus between the PS/2 receive FIFO, the scan-code sequencer and the key-event consumer.
// The sequencer takes the master modport; the FIFO and consumer side takes the slave modport.
interface ps2_key_ctrl_if;
  // FIFO side: a byte moves when kbd_ready && kbd_rd in the same cycle.
  // Event side: an event moves when evt_valid && evt_ready in the same cycle. Once
  // evt_valid is high, evt_code/evt_ext/evt_break hold until that cycle.
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       kbd_rd;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    input  kbd_ready, kbd_data, kbd_overflow, evt_ready,
    output kbd_rd, evt_valid, evt_code, evt_ext, evt_break
  );

  modport slave (
    output kbd_ready, kbd_data, kbd_overflow, evt_ready,
    input  kbd_rd, evt_valid, evt_code, evt_ext, evt_break
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Set-2 scan-code sequencer: pops FIFO bytes, strips E0/F0 prefixes and emits key events.
// Optional macro PS2_REPEAT_FILTER_EN suppresses typematic repeats of the currently held key.
module ps2_key_ctrl #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic                 clk,
  input  logic                 clrn,
  ps2_key_ctrl_if.master       bus,
  output logic [CNT_W-1:0]     press_cnt,
  output logic [ERR_W-1:0]     err_cnt,
  output logic                 ovf_seen,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             evt_valid_q;
  logic [7:0]       evt_code_q;
  logic             evt_ext_q;
  logic             evt_break_q;
  logic [CNT_W-1:0] press_cnt_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             ovf_seen_q;
  logic             held_valid_q;
  logic [7:0]       held_code_q;
  logic             held_ext_q;

  logic       stall;
  logic       pop;
  logic       is_e0, is_f0, is_ign, is_key;
  logic       emit_d, brk_d, ext_d, err_d;
  logic       held_match;
  logic       filt_d;
  logic       fire_d;

  assign stall  = evt_valid_q && !bus.evt_ready;
  assign pop    = bus.kbd_ready && !stall && !bus.kbd_overflow;
  assign bus.kbd_rd = pop;

  assign is_e0  = (bus.kbd_data == 8'hE0);
  assign is_f0  = (bus.kbd_data == 8'hF0);
  assign is_ign = (bus.kbd_data == 8'h00) || (bus.kbd_data == 8'hAA) ||
                  (bus.kbd_data == 8'hE1) || (bus.kbd_data == 8'hFA) ||
                  (bus.kbd_data == 8'hFE) || (bus.kbd_data == 8'hFF);
  assign is_key = !is_e0 && !is_f0 && !is_ign;

  // Byte decode: ignored codes fall through with no state change.
  always_comb begin
    state_d = state_q;
    emit_d  = 1'b0;
    brk_d   = 1'b0;
    ext_d   = 1'b0;
    err_d   = 1'b0;
    if (bus.kbd_overflow) begin
      state_d = S_IDLE;
    end else if (pop && !is_ign) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_e0)      state_d = S_E0;
          else if (is_f0) state_d = S_F0;
          else            emit_d  = 1'b1;
        end
        S_E0: begin
          if (is_f0)      state_d = S_E0F0;
          else if (is_e0) state_d = S_E0;
          else begin
            emit_d  = 1'b1;
            ext_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_F0, S_E0F0: begin
          state_d = S_IDLE;
          if (is_key) begin
            emit_d = 1'b1;
            brk_d  = 1'b1;
            ext_d  = (state_q == S_E0F0);
          end else begin
            err_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign held_match = held_valid_q && (held_code_q == bus.kbd_data) && (held_ext_q == ext_d);

`ifdef PS2_REPEAT_FILTER_EN
  assign filt_d = emit_d && !brk_d && held_match;
`else
  assign filt_d = 1'b0;
`endif

  assign fire_d = emit_d && !filt_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= S_IDLE;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 8'h00;
      evt_ext_q    <= 1'b0;
      evt_break_q  <= 1'b0;
      press_cnt_q  <= '0;
      err_cnt_q    <= '0;
      ovf_seen_q   <= 1'b0;
      held_valid_q <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.kbd_overflow) ovf_seen_q <= 1'b1;

      // A new event may replace one being accepted in the same cycle.
      if (fire_d) begin
        evt_valid_q <= 1'b1;
        evt_code_q  <= bus.kbd_data;
        evt_ext_q   <= ext_d;
        evt_break_q <= brk_d;
      end else if (evt_valid_q && bus.evt_ready) begin
        evt_valid_q <= 1'b0;
      end

      if (fire_d && !brk_d) press_cnt_q <= press_cnt_q + 1'b1;
      if (err_d && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_q <= err_cnt_q + 1'b1;

      if (emit_d && !brk_d) begin
        held_valid_q <= 1'b1;
        held_code_q  <= bus.kbd_data;
        held_ext_q   <= ext_d;
      end else if (fire_d && brk_d && held_match) begin
        held_valid_q <= 1'b0;
      end
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_ext   = evt_ext_q;
  assign bus.evt_break = evt_break_q;
  assign press_cnt     = press_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign ovf_seen      = ovf_seen_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: FIFO model, prefix-flag reference model checked every
// cycle, and literal expectations for each scenario.
module tb_ps2_key_ctrl;
  localparam int CNT_W = 8;
  localparam int ERR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_key_ctrl_if bus();
  logic [CNT_W-1:0] press_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             ovf_seen;
  logic [1:0]       dbg_state;

  ps2_key_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .clrn(clrn), .bus(bus),
    .press_cnt(press_cnt), .err_cnt(err_cnt), .ovf_seen(ovf_seen), .dbg_state_o(dbg_state)
  );

  // ---------------- bench state ----------------
  logic [7:0]  fifo_q[$];
  logic        rdy_v = 1'b1;
  logic        ovf_v = 1'b0;
  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];
  int          vld_cycles = 0;
  int          total = 0;
  int          bad = 0;

  // reference model: pending-prefix flags instead of a state machine
  logic             m_vld = 1'b0;
  logic [7:0]       m_code = 8'h00;
  logic             m_ext = 1'b0, m_brk = 1'b0;
  logic [CNT_W-1:0] m_press = '0;
  logic [ERR_W-1:0] m_err = '0;
  logic             m_ovf = 1'b0;
  logic             pend_ext = 1'b0, pend_brk = 1'b0;
  logic             held_v = 1'b0;
  logic [7:0]       held_code = 8'h00;
  logic             held_ext = 1'b0;
  logic             fired;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_vld = 0; m_code = 0; m_ext = 0; m_brk = 0; m_press = '0; m_err = '0; m_ovf = 0;
    pend_ext = 0; pend_brk = 0; held_v = 0; held_code = 0; held_ext = 0;
  endtask

  task automatic m_emit(input logic [7:0] c, input logic x, input logic k);
    logic filt;
    filt = 1'b0;
    if (!k) begin
`ifdef PS2_REPEAT_FILTER_EN
      filt = held_v && (held_code == c) && (held_ext == x);
`endif
      held_v = 1'b1; held_code = c; held_ext = x;
      if (filt) return;
      m_press = m_press + 1'b1;
    end else if (held_v && (held_code == c) && (held_ext == x)) begin
      held_v = 1'b0;
    end
    m_vld = 1'b1; m_code = c; m_ext = x; m_brk = k; fired = 1'b1;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF}) return;
    if (b == 8'hE0 || b == 8'hF0) begin
      if (pend_brk) begin
        if (m_err != '1) m_err = m_err + 1'b1;
        pend_brk = 1'b0; pend_ext = 1'b0;
      end else if (b == 8'hE0) pend_ext = 1'b1;
      else pend_brk = 1'b1;
    end else begin
      m_emit(b, pend_ext, pend_brk);
      pend_ext = 1'b0; pend_brk = 1'b0;
    end
  endtask

  // ---------------- compare process (every negedge) ----------------
  always @(negedge clk) begin
    logic exp_rd;
    logic done;
    bus.kbd_ready    = (fifo_q.size() != 0);
    bus.kbd_data     = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bus.kbd_overflow = ovf_v;
    bus.evt_ready    = rdy_v;
    #1;
    if (!clrn) begin
      m_reset();
      chk("rst_evt_valid", int'(bus.evt_valid), 0);
      chk("rst_evt_code",  int'(bus.evt_code), 0);
      chk("rst_evt_ext",   int'(bus.evt_ext), 0);
      chk("rst_evt_break", int'(bus.evt_break), 0);
      chk("rst_press_cnt", int'(press_cnt), 0);
      chk("rst_err_cnt",   int'(err_cnt), 0);
      chk("rst_ovf_seen",  int'(ovf_seen), 0);
    end else begin
      exp_rd = (fifo_q.size() != 0) && !(m_vld && !rdy_v) && !ovf_v;
      chk("kbd_rd",    int'(bus.kbd_rd), int'(exp_rd));
      chk("evt_valid", int'(bus.evt_valid), int'(m_vld));
      if (m_vld) begin
        chk("evt_code",  int'(bus.evt_code), int'(m_code));
        chk("evt_ext",   int'(bus.evt_ext), int'(m_ext));
        chk("evt_break", int'(bus.evt_break), int'(m_brk));
      end
      chk("press_cnt", int'(press_cnt), int'(m_press));
      chk("err_cnt",   int'(err_cnt), int'(m_err));
      chk("ovf_seen",  int'(ovf_seen), int'(m_ovf));
      if (bus.evt_valid && bus.evt_ready) got_q.push_back({bus.evt_break, bus.evt_ext, bus.evt_code});
      if (bus.evt_valid) vld_cycles++;
      // advance the model across the coming posedge
      done  = m_vld && rdy_v;
      fired = 1'b0;
      if (ovf_v) begin
        pend_ext = 1'b0; pend_brk = 1'b0; m_ovf = 1'b1;
      end
      if (exp_rd) m_byte(fifo_q.pop_front());
      if (!fired && done) m_vld = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (fifo_q.size() == 0 && !m_vld) return;
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 clrn = 1'b0;
    fifo_q.delete();
    @(posedge clk); #2 clrn = 1'b1;
  endtask

  task automatic exp_evt(input logic k, input logic x, input logic [7:0] c);
    exp_q.push_back({k, x, c});
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_evt"}, int'(got_q[i]), int'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    vld_cycles = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2 clrn = 1'b1;
    chk("rst_dbg_state", int'(dbg_state), 0);
    got_q.delete(); vld_cycles = 0;

    // make then break with consumer always ready
    send(8'h1C); send(8'hF0); send(8'h1C);
    wait_idle("t1", 50);
    chk("t1_vld_cycles", vld_cycles, 2);
    exp_evt(0, 0, 8'h1C); exp_evt(1, 0, 8'h1C);
    check_log("t1");
    chk("t1_press", int'(press_cnt), 1);

    // extended key, with ignored bytes in the middle of prefixes
    send(8'hE0); send(8'hFA); send(8'h75); send(8'hE0); send(8'hF0); send(8'h00); send(8'h75);
    wait_idle("t2", 50);
    chk("t2_vld_cycles", vld_cycles, 2);
    exp_evt(0, 1, 8'h75); exp_evt(1, 1, 8'h75);
    check_log("t2");
    chk("t2_press", int'(press_cnt), 2);

    // back-pressure
    @(posedge clk); rdy_v = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24);
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    chk("t3_held_code", int'(bus.evt_code), 8'h15);
    chk("t3_held_valid", int'(bus.evt_valid), 1);
    chk("t3_fifo_left", fifo_q.size(), 2);
    @(posedge clk); rdy_v = 1'b1;
    wait_idle("t3", 50);
    exp_evt(0, 0, 8'h15); exp_evt(0, 0, 8'h1D); exp_evt(0, 0, 8'h24);
    check_log("t3");
    chk("t3_press", int'(press_cnt), 5);

    // double break prefix is an error
    send(8'hF0); send(8'hF0); send(8'h2B);
    wait_idle("t4", 50);
    chk("t4_err", int'(err_cnt), 1);
    exp_evt(0, 0, 8'h2B);
    check_log("t4");
    chk("t4_press", int'(press_cnt), 6);

    // reset in the middle of an extended sequence
    send(8'hE0);
    wait_idle("t4b", 50);
    pulse_reset();
    chk("t4_rst_valid", int'(bus.evt_valid), 0);
    chk("t4_rst_press", int'(press_cnt), 0);
    chk("t4_rst_err", int'(err_cnt), 0);
    chk("t4_rst_state", int'(dbg_state), 0);
    got_q.delete(); vld_cycles = 0;
    send(8'h1C);
    wait_idle("t4c", 50);
    exp_evt(0, 0, 8'h1C);
    check_log("t4c");
    chk("t4c_press", int'(press_cnt), 1);
    send(8'hF0); send(8'h1C);
    wait_idle("t4d", 50);
    exp_evt(1, 0, 8'h1C);
    check_log("t4d");

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    wait_idle("t5", 50);
`ifdef PS2_REPEAT_FILTER_EN
    exp_evt(0, 0, 8'h1C); exp_evt(1, 0, 8'h1C);
    check_log("t5");
    chk("t5_press", int'(press_cnt), 2);
`else
    exp_evt(0, 0, 8'h1C); exp_evt(0, 0, 8'h1C); exp_evt(0, 0, 8'h1C); exp_evt(1, 0, 8'h1C);
    check_log("t5");
    chk("t5_press", int'(press_cnt), 4);
`endif

    // overflow drops the pending E0 and blocks popping
    send(8'hE0);
    wait_idle("t6", 50);
    @(posedge clk); ovf_v = 1'b1; send(8'h74);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("t6_fifo_blocked", fifo_q.size(), 1);
    chk("t6_ovf_seen", int'(ovf_seen), 1);
    chk("t6_state_idle", int'(dbg_state), 0);
    @(posedge clk); ovf_v = 1'b0;
    wait_idle("t6b", 50);
    exp_evt(0, 0, 8'h74);
    check_log("t6");
`ifdef PS2_REPEAT_FILTER_EN
    chk("t6_press", int'(press_cnt), 3);
`else
    chk("t6_press", int'(press_cnt), 5);
`endif

    // press counter wrap
    pulse_reset();
    got_q.delete(); vld_cycles = 0;
    for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h1B);
    wait_idle("t7", 600);
    chk("t7_press_255", int'(press_cnt), 255);
    send(8'h1B);
    wait_idle("t7b", 50);
    chk("t7_press_wrap", int'(press_cnt), 0);
    chk("t7_events", got_q.size(), 256);
    got_q.delete();

    // error counter saturation
    for (int i = 0; i < 17; i++) begin send(8'hF0); send(8'hF0); end
    wait_idle("t8", 200);
    chk("t8_err_sat", int'(err_cnt), 15);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
